// File: rtl/da2_sample_scheduler.sv
// Paces buffered XADC samples into the PmodDA2 driver: one START per slot, busy/done tracking.
// Build option DA2_SCHED_HOLD_EN: resend the previous DAC word when the FIFO is empty at a tick.
module da2_sample_scheduler #(
    parameter int unsigned SAMPLE_DIV = 20,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [11:0]                 in_data,
    input  logic                        in_valid,
    input  logic                        da_done,
    output logic [11:0]                 da_data1,
    output logic [11:0]                 da_data2,
    output logic                        da_start,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  overrun_cnt,
    output logic [7:0]                  miss_cnt,
    output logic                        timeout_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   slot_cnt;
    logic            tick;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [11:0]     mem [FIFO_DEPTH];
    logic            fifo_empty, fifo_full;
    logic            wr_req, wr_ok, pop;
    logic [TW-1:0]   to_cnt;
    logic            to_hit, set_timeout;
    logic            miss_evt, overrun_evt;

    assign tick = en && (slot_cnt == CW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              slot_cnt <= '0;
        else if (!en || tick)  slot_cnt <= '0;
        else                   slot_cnt <= slot_cnt + 1'b1;
    end

    assign fifo_level  = wr_ptr - rd_ptr;
    assign fifo_empty  = (fifo_level == '0);
    assign fifo_full   = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign wr_req      = in_valid && en;
    // A pop in the same cycle frees the slot the write needs.
    assign wr_ok       = wr_req && (!fifo_full || pop);
    assign overrun_evt = wr_req && fifo_full && !pop;
    assign miss_evt    = tick && ((state_q != IDLE) || fifo_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
`ifdef DA2_SCHED_HOLD_EN
                else if (tick) begin
                    state_d = START;
                end
`endif
            end
            LOAD:  state_d = START;
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!da_done) begin
                    state_d = WAIT_DONE;
                end else if (to_hit) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (da_done) begin
                    state_d = IDLE;
                end else if (to_hit) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == state_q && (state_q == WAIT_BUSY || state_q == WAIT_DONE))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end

    // Data is captured on the pop edge so it is settled for the whole LOAD cycle before START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            da_data1    <= '0;
            da_data2    <= '0;
            da_start    <= 1'b0;
            overrun_cnt <= '0;
            miss_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            da_start <= (state_d == START);
            if (pop) begin
                da_data1 <= mem[rd_ptr[AW-1:0]];
                da_data2 <= mem[rd_ptr[AW-1:0]];
            end
            if (overrun_evt && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
            if (miss_evt && miss_cnt != '1)       miss_cnt    <= miss_cnt + 1'b1;
            if (set_timeout)                      timeout_err <= 1'b1;
        end
    end

endmodule
